br_resolve: RTL and testbench

- Retire-side consumer of the Branch Ordering Buffer (BOB).
- On each retiring conditional or indirect branch:
  - pops the oldest BOB entry;
  - compares the predicted direction with the resolved outcome;
  - emits a registered predictor-update packet (BHT/BHR/choice PHT).
- On a misprediction it runs a recovery sequence: flush, redirect PC, and restore global history and RAS pointer to the fetch stage.

---
 rtl/br_pkg.sv | 21 ++
 rtl/br_perfcnt.sv | 40 ++++
 rtl/br_resolve.sv | 199 +++++++++++++++++++
 tb/tb_br_resolve.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/br_pkg.sv
// rtl/br_pkg.sv - shared state type and default widths for branch resolution
package br_pkg;

  // Resolution FSM: waiting for retiring branches, or holding the flush after a mispredict
  typedef enum logic {
    BRR_IDLE    = 1'b0,
    BRR_RECOVER = 1'b1
  } brr_state_e;

  // Default history / pointer widths for the predictor structures
  localparam int BHT_W = 10;
  localparam int BHR_W = 12;
  localparam int RAS_W = 4;

  // Default number of cycles flush is held during recovery
  localparam int FLUSH_CYC = 2;

  // Size of one fetched instruction; the fall-through PC is brpc + INSN_BYTES
  localparam int INSN_BYTES = 4;

endpackage

// File: rtl/br_perfcnt.sv
// rtl/br_perfcnt.sv - saturating retired-branch and mispredict counters (built under BR_PERFCNT_EN)
module br_perfcnt (
  input  logic        clock,
  input  logic        reset,
  input  logic        inc_ret_i,
  input  logic        inc_miss_i,
  output logic [31:0] brret_o,
  output logic [31:0] brmiss_o
);

  logic [31:0] brret_q, brret_d;
  logic [31:0] brmiss_q, brmiss_d;

  // Each counter advances on its pulse and parks at all-ones instead of wrapping
  always_comb begin
    brret_d  = brret_q;
    brmiss_d = brmiss_q;
    if (inc_ret_i && (brret_q != 32'hFFFF_FFFF)) begin
      brret_d = brret_q + 32'd1;
    end
    if (inc_miss_i && (brmiss_q != 32'hFFFF_FFFF)) begin
      brmiss_d = brmiss_q + 32'd1;
    end
  end

  // Counters are cleared by reset only
  always_ff @(posedge clock) begin
    if (reset) begin
      brret_q  <= 32'd0;
      brmiss_q <= 32'd0;
    end else begin
      brret_q  <= brret_d;
      brmiss_q <= brmiss_d;
    end
  end

  assign brret_o  = brret_q;
  assign brmiss_o = brmiss_q;

endmodule

// File: rtl/br_resolve.sv
// rtl/br_resolve.sv - retire-side BOB consumer: predictor update and mispredict recovery (optional BR_PERFCNT_EN counters)
module br_resolve #(
  parameter int PC_W      = 64,
  parameter int BHT_W     = br_pkg::BHT_W,
  parameter int BHR_W     = br_pkg::BHR_W,
  parameter int RAS_W     = br_pkg::RAS_W,
  parameter int FLUSH_CYC = br_pkg::FLUSH_CYC
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             brcond_vld_rt_i,
  input  logic             brindir_vld_rt_i,
  input  logic             br_taken_rt_i,
  input  logic [PC_W-1:0]  br_target_rt_i,
  input  logic             br_indirmiss_rt_i,
  input  logic             bob_valid_i,
  input  logic [PC_W-1:0]  bob_brpc_i,
  input  logic             bob_brdir_i,
  input  logic             bob_chwe_i,
  input  logic             bob_chbrdir_i,
  input  logic [BHT_W-1:0] bob_bht_i,
  input  logic [BHR_W-1:0] bob_bhr_i,
  input  logic [RAS_W-1:0] bob_rasptr_i,
  output logic             bob_re_o,
  output logic             upd_vld_o,
  output logic [PC_W-1:0]  upd_pc_o,
  output logic             upd_taken_o,
  output logic             upd_chwe_o,
  output logic             upd_chdir_o,
  output logic [BHT_W-1:0] upd_bht_o,
  output logic [BHR_W-1:0] upd_bhr_o,
  output logic             flush_o,
  output logic             redirect_vld_o,
  output logic [PC_W-1:0]  redirect_pc_o,
  output logic [BHR_W-1:0] restore_bhr_o,
  output logic [RAS_W-1:0] restore_rasptr_o,
  output logic             err_underflow_o
`ifdef BR_PERFCNT_EN
  ,
  output logic [31:0]      perf_brret_o,
  output logic [31:0]      perf_brmiss_o
`endif
);

  import br_pkg::*;

  // Recovery counter starts at FLUSH_CYC-1 so flush spans exactly FLUSH_CYC cycles
  localparam logic [3:0] RCNT_INIT = 4'(FLUSH_CYC - 1);

  brr_state_e state_q, state_d;
  logic [3:0] rcnt_q, rcnt_d;

  logic             upd_vld_q, upd_vld_d;
  logic [PC_W-1:0]  upd_pc_q, upd_pc_d;
  logic             upd_taken_q, upd_taken_d;
  logic             upd_chwe_q, upd_chwe_d;
  logic             upd_chdir_q, upd_chdir_d;
  logic [BHT_W-1:0] upd_bht_q, upd_bht_d;
  logic [BHR_W-1:0] upd_bhr_q, upd_bhr_d;
  logic             redirect_vld_q, redirect_vld_d;
  logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
  logic [BHR_W-1:0] restore_bhr_q, restore_bhr_d;
  logic [RAS_W-1:0] restore_rasptr_q, restore_rasptr_d;
  logic             err_q, err_d;

  logic            ev;
  logic            miss;
  logic            shift_bit;
  logic            pop;
  logic [PC_W-1:0] fallthru_pc;

  // The oldest local-history bit is shifted out and never consumed
  logic unused_bht_msb;
  assign unused_bht_msb = bob_bht_i[BHT_W-1];

  // Event decode: a cond+indir retire is a single cond event; indirects always shift in taken
  always_comb begin
    ev          = brcond_vld_rt_i | brindir_vld_rt_i;
    miss        = brcond_vld_rt_i ? (bob_brdir_i != br_taken_rt_i) : br_indirmiss_rt_i;
    shift_bit   = brcond_vld_rt_i ? br_taken_rt_i : 1'b1;
    fallthru_pc = bob_brpc_i + PC_W'(INSN_BYTES);
  end

  // Next-state and registered-output decode; pulses default low, data fields hold
  always_comb begin
    state_d          = state_q;
    rcnt_d           = rcnt_q;
    pop              = 1'b0;
    upd_vld_d        = 1'b0;
    upd_pc_d         = upd_pc_q;
    upd_taken_d      = upd_taken_q;
    upd_chwe_d       = upd_chwe_q;
    upd_chdir_d      = upd_chdir_q;
    upd_bht_d        = upd_bht_q;
    upd_bhr_d        = upd_bhr_q;
    redirect_vld_d   = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    restore_bhr_d    = restore_bhr_q;
    restore_rasptr_d = restore_rasptr_q;
    err_d            = err_q;
    case (state_q)
      BRR_IDLE: begin
        if (ev && !bob_valid_i) begin
          err_d = 1'b1;
        end else if (ev) begin
          pop = 1'b1;
          if (brcond_vld_rt_i) begin
            upd_vld_d   = 1'b1;
            upd_pc_d    = bob_brpc_i;
            upd_taken_d = br_taken_rt_i;
            upd_chwe_d  = bob_chwe_i;
            upd_chdir_d = bob_chbrdir_i;
            upd_bht_d   = {bob_bht_i[BHT_W-2:0], br_taken_rt_i};
            upd_bhr_d   = bob_bhr_i;
          end
          if (miss) begin
            redirect_vld_d   = 1'b1;
            redirect_pc_d    = shift_bit ? br_target_rt_i : fallthru_pc;
            restore_bhr_d    = {bob_bhr_i[BHR_W-2:0], shift_bit};
            restore_rasptr_d = bob_rasptr_i;
            state_d          = BRR_RECOVER;
            rcnt_d           = RCNT_INIT;
          end
        end
      end
      BRR_RECOVER: begin
        if (rcnt_q == 4'd0) begin
          state_d = BRR_IDLE;
        end else begin
          rcnt_d = rcnt_q - 4'd1;
        end
      end
      default: state_d = BRR_IDLE;
    endcase
  end

  // State and output registers; reset drops everything back to a quiet IDLE
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= BRR_IDLE;
      rcnt_q           <= 4'd0;
      upd_vld_q        <= 1'b0;
      upd_pc_q         <= '0;
      upd_taken_q      <= 1'b0;
      upd_chwe_q       <= 1'b0;
      upd_chdir_q      <= 1'b0;
      upd_bht_q        <= '0;
      upd_bhr_q        <= '0;
      redirect_vld_q   <= 1'b0;
      redirect_pc_q    <= '0;
      restore_bhr_q    <= '0;
      restore_rasptr_q <= '0;
      err_q            <= 1'b0;
    end else begin
      state_q          <= state_d;
      rcnt_q           <= rcnt_d;
      upd_vld_q        <= upd_vld_d;
      upd_pc_q         <= upd_pc_d;
      upd_taken_q      <= upd_taken_d;
      upd_chwe_q       <= upd_chwe_d;
      upd_chdir_q      <= upd_chdir_d;
      upd_bht_q        <= upd_bht_d;
      upd_bhr_q        <= upd_bhr_d;
      redirect_vld_q   <= redirect_vld_d;
      redirect_pc_q    <= redirect_pc_d;
      restore_bhr_q    <= restore_bhr_d;
      restore_rasptr_q <= restore_rasptr_d;
      err_q            <= err_d;
    end
  end

  assign bob_re_o         = pop & ~reset;
  assign flush_o          = (state_q == BRR_RECOVER);
  assign upd_vld_o        = upd_vld_q;
  assign upd_pc_o         = upd_pc_q;
  assign upd_taken_o      = upd_taken_q;
  assign upd_chwe_o       = upd_chwe_q;
  assign upd_chdir_o      = upd_chdir_q;
  assign upd_bht_o        = upd_bht_q;
  assign upd_bhr_o        = upd_bhr_q;
  assign redirect_vld_o   = redirect_vld_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign restore_bhr_o    = restore_bhr_q;
  assign restore_rasptr_o = restore_rasptr_q;
  assign err_underflow_o  = err_q;

`ifdef BR_PERFCNT_EN
  // Count every pop and every pop that mispredicted
  br_perfcnt u_perfcnt (
    .clock      (clock),
    .reset      (reset),
    .inc_ret_i  (bob_re_o),
    .inc_miss_i (bob_re_o & miss),
    .brret_o    (perf_brret_o),
    .brmiss_o   (perf_brmiss_o)
  );
`endif

endmodule

// File: tb/tb_br_resolve.sv
// tb/tb_br_resolve.sv - scoreboard bench for br_resolve
module tb_br_resolve;

  logic        clock;
  logic        reset;
  logic        brcond_vld_rt_i, brindir_vld_rt_i, br_taken_rt_i, br_indirmiss_rt_i;
  logic [63:0] br_target_rt_i;
  logic        bob_valid_i, bob_brdir_i, bob_chwe_i, bob_chbrdir_i;
  logic [63:0] bob_brpc_i;
  logic [9:0]  bob_bht_i;
  logic [11:0] bob_bhr_i;
  logic [3:0]  bob_rasptr_i;
  logic        bob_re_o, upd_vld_o, upd_taken_o, upd_chwe_o, upd_chdir_o;
  logic [63:0] upd_pc_o, redirect_pc_o;
  logic [9:0]  upd_bht_o;
  logic [11:0] upd_bhr_o, restore_bhr_o;
  logic        flush_o, redirect_vld_o, err_underflow_o;
  logic [3:0]  restore_rasptr_o;
`ifdef BR_PERFCNT_EN
  logic [31:0] perf_brret_o, perf_brmiss_o;
`endif

  br_resolve dut (
    .clock             (clock),
    .reset             (reset),
    .brcond_vld_rt_i   (brcond_vld_rt_i),
    .brindir_vld_rt_i  (brindir_vld_rt_i),
    .br_taken_rt_i     (br_taken_rt_i),
    .br_target_rt_i    (br_target_rt_i),
    .br_indirmiss_rt_i (br_indirmiss_rt_i),
    .bob_valid_i       (bob_valid_i),
    .bob_brpc_i        (bob_brpc_i),
    .bob_brdir_i       (bob_brdir_i),
    .bob_chwe_i        (bob_chwe_i),
    .bob_chbrdir_i     (bob_chbrdir_i),
    .bob_bht_i         (bob_bht_i),
    .bob_bhr_i         (bob_bhr_i),
    .bob_rasptr_i      (bob_rasptr_i),
    .bob_re_o          (bob_re_o),
    .upd_vld_o         (upd_vld_o),
    .upd_pc_o          (upd_pc_o),
    .upd_taken_o       (upd_taken_o),
    .upd_chwe_o        (upd_chwe_o),
    .upd_chdir_o       (upd_chdir_o),
    .upd_bht_o         (upd_bht_o),
    .upd_bhr_o         (upd_bhr_o),
    .flush_o           (flush_o),
    .redirect_vld_o    (redirect_vld_o),
    .redirect_pc_o     (redirect_pc_o),
    .restore_bhr_o     (restore_bhr_o),
    .restore_rasptr_o  (restore_rasptr_o),
    .err_underflow_o   (err_underflow_o)
`ifdef BR_PERFCNT_EN
    ,
    .perf_brret_o      (perf_brret_o),
    .perf_brmiss_o     (perf_brmiss_o)
`endif
  );

  typedef struct packed {
    logic [63:0] pc;
    logic        taken;
    logic        chwe;
    logic        chdir;
    logic [9:0]  bht;
    logic [11:0] bhr;
  } upd_t;

  upd_t upd_q[$];
  upd_t exp_u, got_u;
  int   tests = 0;
  int   fails = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic set_entry(input logic v, input logic [63:0] pc, input logic dir, input logic chwe,
                           input logic chdir, input logic [9:0] bht, input logic [11:0] bhr,
                           input logic [3:0] ras);
    bob_valid_i   = v;
    bob_brpc_i    = pc;
    bob_brdir_i   = dir;
    bob_chwe_i    = chwe;
    bob_chbrdir_i = chdir;
    bob_bht_i     = bht;
    bob_bhr_i     = bhr;
    bob_rasptr_i  = ras;
  endtask

  task automatic set_retire(input logic cond, input logic indir, input logic tk,
                            input logic [63:0] tgt, input logic imiss);
    brcond_vld_rt_i   = cond;
    brindir_vld_rt_i  = indir;
    br_taken_rt_i     = tk;
    br_target_rt_i    = tgt;
    br_indirmiss_rt_i = imiss;
  endtask

  task automatic clear_retire;
    set_retire(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
  endtask

  task automatic test_reset;
    clear_retire();
    set_entry(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 10'h0, 12'h0, 4'h0);
    reset = 1'b1;
    repeat (2) tick();
    tests++;
    if ({upd_vld_o, flush_o, redirect_vld_o, err_underflow_o, bob_re_o, upd_taken_o, upd_chwe_o, upd_chdir_o} !== 8'h0 ||
        upd_pc_o !== 64'h0 || redirect_pc_o !== 64'h0 || restore_bhr_o !== 12'h0 ||
        restore_rasptr_o !== 4'h0 || upd_bht_o !== 10'h0 || upd_bhr_o !== 12'h0) begin
      fails++;
      $display("FAIL reset_outputs: upd_vld=%b flush=%b redir=%b err=%b re=%b redir_pc=%h, required all zero",
               upd_vld_o, flush_o, redirect_vld_o, err_underflow_o, bob_re_o, redirect_pc_o);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_correct_taken;
    @(negedge clock);
    set_entry(1'b1, 64'h2000, 1'b1, 1'b1, 1'b0, 10'h001, 12'h155, 4'h3);
    set_retire(1'b1, 1'b0, 1'b1, 64'h3000, 1'b0);
    #1;
    tests++;
    if (bob_re_o !== 1'b1) begin fails++; $display("FAIL correct_pop: bob_re_o=%b required 1", bob_re_o); end
    upd_q.push_back({64'h2000, 1'b1, 1'b1, 1'b0, 10'h003, 12'h155});
    tick();
    clear_retire();
    tests++;
    if (upd_vld_o !== 1'b1 || upd_q.size() == 0) begin
      fails++; $display("FAIL correct_upd_vld: upd_vld_o=%b required 1", upd_vld_o);
    end else begin
      exp_u = upd_q.pop_front();
      got_u = {upd_pc_o, upd_taken_o, upd_chwe_o, upd_chdir_o, upd_bht_o, upd_bhr_o};
      if (got_u !== exp_u) begin fails++; $display("FAIL correct_upd_pkt: got %h required %h", got_u, exp_u); end
    end
    tests++;
    if (flush_o !== 1'b0 || redirect_vld_o !== 1'b0) begin
      fails++; $display("FAIL correct_no_flush: flush=%b redir=%b required 0 0", flush_o, redirect_vld_o);
    end
    tick();
    tests++;
    if (upd_vld_o !== 1'b0) begin fails++; $display("FAIL correct_upd_one_cycle: upd_vld_o=%b required 0", upd_vld_o); end
  endtask

  task automatic test_mispredict_not_taken;
    int nflush;
    @(negedge clock);
    set_entry(1'b1, 64'h1000, 1'b1, 1'b0, 1'b1, 10'h2AA, 12'hABC, 4'h5);
    set_retire(1'b1, 1'b0, 1'b0, 64'h5555, 1'b0);
    #1;
    tests++;
    if (bob_re_o !== 1'b1) begin fails++; $display("FAIL miss_pop: bob_re_o=%b required 1", bob_re_o); end
    upd_q.push_back({64'h1000, 1'b0, 1'b0, 1'b1, 10'h154, 12'hABC});
    tick();
    clear_retire();
    tests++;
    if (upd_vld_o !== 1'b1 || upd_q.size() == 0) begin
      fails++; $display("FAIL miss_upd_vld: upd_vld_o=%b required 1", upd_vld_o);
    end else begin
      exp_u = upd_q.pop_front();
      got_u = {upd_pc_o, upd_taken_o, upd_chwe_o, upd_chdir_o, upd_bht_o, upd_bhr_o};
      if (got_u !== exp_u) begin fails++; $display("FAIL miss_upd_pkt: got %h required %h", got_u, exp_u); end
    end
    tests++;
    if ({redirect_vld_o, redirect_pc_o, restore_bhr_o, restore_rasptr_o, flush_o} !== {1'b1, 64'h1004, 12'h578, 4'h5, 1'b1}) begin
      fails++;
      $display("FAIL miss_recovery: redir=%b pc=%h bhr=%h ras=%h flush=%b required 1 0000000000001004 578 5 1",
               redirect_vld_o, redirect_pc_o, restore_bhr_o, restore_rasptr_o, flush_o);
    end
    nflush = (flush_o === 1'b1) ? 1 : 0;
    tick();
    tests++;
    if (redirect_vld_o !== 1'b0) begin fails++; $display("FAIL miss_redirect_one_cycle: redirect_vld_o=%b required 0", redirect_vld_o); end
    for (int i = 0; i < 8 && flush_o === 1'b1; i++) begin
      nflush++;
      tick();
    end
    tests++;
    if (nflush != 2) begin fails++; $display("FAIL miss_flush_len: flush cycles=%0d required 2", nflush); end
  endtask

  task automatic test_events_during_recover;
    @(negedge clock);
    set_entry(1'b1, 64'h40, 1'b0, 1'b1, 1'b1, 10'h3FF, 12'h001, 4'h2);
    set_retire(1'b1, 1'b0, 1'b1, 64'h8000, 1'b0);
    upd_q.push_back({64'h40, 1'b1, 1'b1, 1'b1, 10'h3FF, 12'h001});
    tick();
    clear_retire();
    tests++;
    if (upd_vld_o !== 1'b1 || upd_q.size() == 0) begin
      fails++; $display("FAIL rec_upd_vld: upd_vld_o=%b required 1", upd_vld_o);
    end else begin
      exp_u = upd_q.pop_front();
      got_u = {upd_pc_o, upd_taken_o, upd_chwe_o, upd_chdir_o, upd_bht_o, upd_bhr_o};
      if (got_u !== exp_u) begin fails++; $display("FAIL rec_upd_pkt: got %h required %h", got_u, exp_u); end
    end
    tests++;
    if ({redirect_vld_o, redirect_pc_o, restore_bhr_o, restore_rasptr_o, flush_o} !== {1'b1, 64'h8000, 12'h003, 4'h2, 1'b1}) begin
      fails++;
      $display("FAIL rec_recovery: redir=%b pc=%h bhr=%h ras=%h flush=%b required 1 0000000000008000 003 2 1",
               redirect_vld_o, redirect_pc_o, restore_bhr_o, restore_rasptr_o, flush_o);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      set_entry(1'b1, 64'h80 + 64'(i * 4), 1'b1, 1'b0, 1'b0, 10'h0, 12'h0, 4'h0);
      set_retire(1'b1, 1'b0, 1'b1, 64'h9000, 1'b0);
      #1;
      tests++;
      if (bob_re_o !== 1'b0) begin fails++; $display("FAIL rec_ignore_pop%0d: bob_re_o=%b required 0", i, bob_re_o); end
      tick();
      clear_retire();
      tests++;
      if (upd_vld_o !== 1'b0 || redirect_vld_o !== 1'b0) begin
        fails++; $display("FAIL rec_ignore_upd%0d: upd_vld=%b redir=%b required 0 0", i, upd_vld_o, redirect_vld_o);
      end
    end
    tests++;
    if (flush_o !== 1'b0) begin fails++; $display("FAIL rec_flush_end: flush_o=%b required 0", flush_o); end
  endtask

  task automatic test_indirect_miss;
    @(negedge clock);
    set_entry(1'b1, 64'h100, 1'b0, 1'b1, 1'b0, 10'h0, 12'h800, 4'h9);
    set_retire(1'b0, 1'b1, 1'b1, 64'hABCD_0000, 1'b1);
    #1;
    tests++;
    if (bob_re_o !== 1'b1) begin fails++; $display("FAIL indir_pop: bob_re_o=%b required 1", bob_re_o); end
    tick();
    clear_retire();
    tests++;
    if (upd_vld_o !== 1'b0) begin fails++; $display("FAIL indir_no_upd: upd_vld_o=%b required 0", upd_vld_o); end
    tests++;
    if ({redirect_vld_o, redirect_pc_o, restore_bhr_o, restore_rasptr_o, flush_o} !== {1'b1, 64'hABCD_0000, 12'h001, 4'h9, 1'b1}) begin
      fails++;
      $display("FAIL indir_recovery: redir=%b pc=%h bhr=%h ras=%h flush=%b required 1 00000000abcd0000 001 9 1",
               redirect_vld_o, redirect_pc_o, restore_bhr_o, restore_rasptr_o, flush_o);
    end
    for (int i = 0; i < 8 && flush_o === 1'b1; i++) tick();
    tests++;
    if (flush_o !== 1'b0) begin fails++; $display("FAIL indir_flush_end: flush_o=%b required 0", flush_o); end
  endtask

  task automatic test_cond_wins;
    @(negedge clock);
    set_entry(1'b1, 64'h200, 1'b1, 1'b0, 1'b0, 10'h155, 12'h0F0, 4'h1);
    set_retire(1'b1, 1'b1, 1'b1, 64'h7000, 1'b1);
    upd_q.push_back({64'h200, 1'b1, 1'b0, 1'b0, 10'h2AB, 12'h0F0});
    tick();
    clear_retire();
    tests++;
    if (upd_vld_o !== 1'b1 || upd_q.size() == 0) begin
      fails++; $display("FAIL both_upd_vld: upd_vld_o=%b required 1", upd_vld_o);
    end else begin
      exp_u = upd_q.pop_front();
      got_u = {upd_pc_o, upd_taken_o, upd_chwe_o, upd_chdir_o, upd_bht_o, upd_bhr_o};
      if (got_u !== exp_u) begin fails++; $display("FAIL both_upd_pkt: got %h required %h", got_u, exp_u); end
    end
    tests++;
    if (flush_o !== 1'b0 || redirect_vld_o !== 1'b0) begin
      fails++; $display("FAIL both_no_flush: flush=%b redir=%b required 0 0", flush_o, redirect_vld_o);
    end
  endtask

  task automatic test_wrap;
    @(negedge clock);
    set_entry(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0, 1'b0, 10'h200, 12'hFFF, 4'hF);
    set_retire(1'b1, 1'b0, 1'b0, 64'h1234, 1'b0);
    upd_q.push_back({64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 1'b0, 10'h000, 12'hFFF});
    tick();
    clear_retire();
    tests++;
    if (upd_vld_o !== 1'b1 || upd_q.size() == 0) begin
      fails++; $display("FAIL wrap_upd_vld: upd_vld_o=%b required 1", upd_vld_o);
    end else begin
      exp_u = upd_q.pop_front();
      got_u = {upd_pc_o, upd_taken_o, upd_chwe_o, upd_chdir_o, upd_bht_o, upd_bhr_o};
      if (got_u !== exp_u) begin fails++; $display("FAIL wrap_upd_pkt: got %h required %h", got_u, exp_u); end
    end
    tests++;
    if ({redirect_vld_o, redirect_pc_o, restore_bhr_o, restore_rasptr_o} !== {1'b1, 64'h0, 12'hFFE, 4'hF}) begin
      fails++;
      $display("FAIL wrap_redirect: redir=%b pc=%h bhr=%h ras=%h required 1 0000000000000000 ffe f",
               redirect_vld_o, redirect_pc_o, restore_bhr_o, restore_rasptr_o);
    end
    for (int i = 0; i < 8 && flush_o === 1'b1; i++) tick();
  endtask

  task automatic test_back_to_back;
    logic [63:0] pcs[3];
    logic        tks[3];
    logic [9:0]  bhts[3];
    logic [11:0] bhrs[3];
    pcs  = '{64'h3000, 64'h3004, 64'h3008};
    tks  = '{1'b1, 1'b0, 1'b1};
    bhts = '{10'h0F0, 10'h201, 10'h3FE};
    bhrs = '{12'h111, 12'h222, 12'h333};
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      set_entry(1'b1, pcs[i], tks[i], i[0], ~i[0], bhts[i], bhrs[i], 4'(i));
      set_retire(1'b1, 1'b0, tks[i], 64'hDEAD_0000, 1'b0);
      #1;
      tests++;
      if (bob_re_o !== 1'b1) begin fails++; $display("FAIL b2b_pop%0d: bob_re_o=%b required 1", i, bob_re_o); end
      upd_q.push_back({pcs[i], tks[i], i[0], ~i[0], bhts[i][8:0], tks[i], bhrs[i]});
      tick();
      tests++;
      if (upd_vld_o !== 1'b1 || upd_q.size() == 0) begin
        fails++; $display("FAIL b2b_upd_vld%0d: upd_vld_o=%b required 1", i, upd_vld_o);
      end else begin
        exp_u = upd_q.pop_front();
        got_u = {upd_pc_o, upd_taken_o, upd_chwe_o, upd_chdir_o, upd_bht_o, upd_bhr_o};
        if (got_u !== exp_u) begin fails++; $display("FAIL b2b_upd_pkt%0d: got %h required %h", i, got_u, exp_u); end
      end
    end
    clear_retire();
    tick();
    tests++;
    if (upd_vld_o !== 1'b0 || flush_o !== 1'b0 || upd_q.size() != 0) begin
      fails++; $display("FAIL b2b_drain: upd_vld=%b flush=%b queued=%0d required 0 0 0", upd_vld_o, flush_o, upd_q.size());
    end
  endtask

  task automatic test_empty_pop;
    @(negedge clock);
    set_entry(1'b0, 64'h700, 1'b1, 1'b0, 1'b0, 10'h0, 12'h0, 4'h0);
    set_retire(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
    #1;
    tests++;
    if (bob_re_o !== 1'b0) begin fails++; $display("FAIL empty_no_pop: bob_re_o=%b required 0", bob_re_o); end
    tick();
    clear_retire();
    tests++;
    if (err_underflow_o !== 1'b1 || upd_vld_o !== 1'b0 || flush_o !== 1'b0) begin
      fails++; $display("FAIL empty_err: err=%b upd_vld=%b flush=%b required 1 0 0", err_underflow_o, upd_vld_o, flush_o);
    end
    repeat (3) tick();
    tests++;
    if (err_underflow_o !== 1'b1) begin fails++; $display("FAIL empty_sticky: err=%b required 1", err_underflow_o); end
  endtask

  task automatic test_reset_in_recover;
    @(negedge clock);
    set_entry(1'b1, 64'h500, 1'b0, 1'b1, 1'b1, 10'h000, 12'h00F, 4'h7);
    set_retire(1'b1, 1'b0, 1'b1, 64'h6000, 1'b0);
    upd_q.push_back({64'h500, 1'b1, 1'b1, 1'b1, 10'h001, 12'h00F});
    tick();
    clear_retire();
    tests++;
    if (upd_vld_o !== 1'b1 || upd_q.size() == 0) begin
      fails++; $display("FAIL rst_rec_upd_vld: upd_vld_o=%b required 1", upd_vld_o);
    end else begin
      exp_u = upd_q.pop_front();
      got_u = {upd_pc_o, upd_taken_o, upd_chwe_o, upd_chdir_o, upd_bht_o, upd_bhr_o};
      if (got_u !== exp_u) begin fails++; $display("FAIL rst_rec_upd_pkt: got %h required %h", got_u, exp_u); end
    end
    tests++;
    if (flush_o !== 1'b1) begin fails++; $display("FAIL rst_rec_enter: flush_o=%b required 1", flush_o); end
    @(negedge clock);
    reset = 1'b1;
    tick();
    tests++;
    if (flush_o !== 1'b0 || redirect_vld_o !== 1'b0 || err_underflow_o !== 1'b0 || upd_vld_o !== 1'b0 ||
        redirect_pc_o !== 64'h0 || restore_bhr_o !== 12'h0) begin
      fails++;
      $display("FAIL rst_rec_clear: flush=%b redir=%b err=%b upd=%b pc=%h bhr=%h required all zero",
               flush_o, redirect_vld_o, err_underflow_o, upd_vld_o, redirect_pc_o, restore_bhr_o);
    end
    @(negedge clock);
    reset = 1'b0;
    set_entry(1'b1, 64'h600, 1'b1, 1'b0, 1'b1, 10'h001, 12'h0AA, 4'h0);
    set_retire(1'b1, 1'b0, 1'b1, 64'h6100, 1'b0);
    #1;
    tests++;
    if (bob_re_o !== 1'b1) begin fails++; $display("FAIL rst_rec_idle_pop: bob_re_o=%b required 1", bob_re_o); end
    upd_q.push_back({64'h600, 1'b1, 1'b0, 1'b1, 10'h003, 12'h0AA});
    tick();
    clear_retire();
    tests++;
    if (upd_vld_o !== 1'b1 || upd_q.size() == 0) begin
      fails++; $display("FAIL rst_rec_after_upd_vld: upd_vld_o=%b required 1", upd_vld_o);
    end else begin
      exp_u = upd_q.pop_front();
      got_u = {upd_pc_o, upd_taken_o, upd_chwe_o, upd_chdir_o, upd_bht_o, upd_bhr_o};
      if (got_u !== exp_u) begin fails++; $display("FAIL rst_rec_after_pkt: got %h required %h", got_u, exp_u); end
    end
    tests++;
    if (flush_o !== 1'b0) begin fails++; $display("FAIL rst_rec_after_flush: flush_o=%b required 0", flush_o); end
  endtask

  initial begin
    reset = 1'b1;
    clear_retire();
    set_entry(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 10'h0, 12'h0, 4'h0);
    test_reset();
    test_correct_taken();
    test_mispredict_not_taken();
    test_events_during_recover();
    test_indirect_miss();
    test_cond_wins();
    test_wrap();
    test_back_to_back();
    test_empty_pop();
    test_reset_in_recover();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
